// File: rtl/and_arb_pkg.sv
// Shared constants, ID-width helper and tracking-pipe stage type for and_rr_arbiter.
package and_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int DP_LAT_DEF  = 1;
    localparam int NUM_REQ_MAX = 16;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Stage ID is sized for the largest legal requester count; the top truncates.
    localparam int ID_W_MAX = id_w(NUM_REQ_MAX);

    typedef struct packed {
        logic                vld;
        logic [ID_W_MAX-1:0] id;
    } pipe_stage_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin pick: first valid request at or above ptr, wrapping.
module rr_grant
    import and_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = id_w(NUM_REQ_DEF)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    always_comb begin
        int   j;
        logic found;
        j       = 0;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (en && !found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/and_rr_arbiter.sv
// Round-robin arbiter sharing one registered-AND datapath; results return tagged with requester ID.
// Optional issue counter with synchronous clear is enabled by defining AND_ARB_CNT_EN.
module and_rr_arbiter
    import and_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DP_LAT  = DP_LAT_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic [DATA_W-1:0]           dp_in0,
    output logic [DATA_W-1:0]           dp_in1,
    input  logic [DATA_W-1:0]           dp_out,
    output logic                        rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        busy
`ifdef AND_ARB_CNT_EN
    ,
    input  logic                        cnt_clr,
    output logic [15:0]                 issue_cnt
`endif
);

    localparam int ID_W = id_w(NUM_REQ);

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               hs;
    pipe_stage_t        pipe [DP_LAT];

    // Handshake: req_valid[i] && req_ready[i]. Grants only go to valid requesters,
    // so any grant bit is a handshake. Reset also suppresses grants.
    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_grant (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (en & rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign hs        = |gnt;

    always_comb begin
        dp_in0 = '0;
        dp_in1 = '0;
        if (hs) begin
            dp_in0 = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
            dp_in1 = req_b[int'(gnt_idx)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    // ID/valid pipe runs in lockstep with the datapath latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DP_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0].vld <= hs;
            pipe[0].id  <= ID_W_MAX'(gnt_idx);
            for (int i = 1; i < DP_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign rsp_valid = pipe[DP_LAT-1].vld;
    assign rsp_id    = pipe[DP_LAT-1].id[ID_W-1:0];
    assign rsp_data  = rsp_valid ? dp_out : '0;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DP_LAT; i++) busy = busy | pipe[i].vld;
    end

`ifdef AND_ARB_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
        end else if (cnt_clr) begin
            issue_cnt <= '0;
        end else if (hs && issue_cnt != 16'hFFFF) begin
            issue_cnt <= issue_cnt + 16'd1;
        end
    end
`endif

endmodule
